// File: rtl/instruction_queue_pkg.sv
// Shared widths and queue sizing for the fetch/decode instruction queue.
// Bus widths mirror the CPU-wide instruction and address bus definitions.
package instruction_queue_pkg;

    localparam int INST_BUS_W  = 32;
    localparam int ADDR_BUS_W  = 32;
    localparam int QUEUE_DEPTH = 16;
    localparam int QUEUE_SLACK = 2;

    typedef logic [INST_BUS_W-1:0] inst_t;
    typedef logic [ADDR_BUS_W-1:0] addr_t;

endpackage

// File: rtl/instruction_queue.sv
// IF->ID instruction FIFO with first-word fall-through head, ROB flush and a
// slack-based full flag so fetches already in flight can still land.
module instruction_queue
    import instruction_queue_pkg::*;
#(
    parameter int DEPTH  = QUEUE_DEPTH,
    parameter int ADDR_W = $clog2(QUEUE_DEPTH),
    parameter int SLACK  = QUEUE_SLACK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_inst_valid,
    input  logic [31:0] IF_inst,
    input  logic [31:0] IF_pc,
    output logic        IF_queue_is_full,
    input  logic        ID_enable,
    output logic        ID_queue_is_empty,
    output logic [31:0] ID_inst,
    output logic [31:0] ID_pc,
    input  logic        ROB_clear
);

    localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(DEPTH - SLACK);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    inst_t inst_mem [DEPTH];
    addr_t pc_mem   [DEPTH];

    logic [ADDR_W-1:0] head_reg;
    logic [ADDR_W-1:0] tail_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              push;
    logic              pop;
    logic              empty;

    assign empty = (count_reg == '0);
    assign pop   = ID_enable && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push  = IF_inst_valid && ((count_reg < DEPTH_CNT) || pop);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (rdy) begin
            if (ROB_clear) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                if (push) tail_reg <= tail_reg + PTR_ONE;
                if (pop)  head_reg <= head_reg + PTR_ONE;
                count_reg <= count_next;
            end
        end
    end

    // Storage has no reset so it can map onto RAM; contents are don't-care after clear.
    always_ff @(posedge clk) begin
        if (rdy && !ROB_clear && push) begin
            inst_mem[tail_reg] <= IF_inst;
            pc_mem[tail_reg]   <= IF_pc;
        end
    end

    always_comb begin
        ID_inst = '0;
        ID_pc   = '0;
        if (!empty) begin
            ID_inst = inst_mem[head_reg];
            ID_pc   = pc_mem[head_reg];
        end
    end

    assign ID_queue_is_empty = empty;
    assign IF_queue_is_full  = (count_reg >= FULL_LEVEL);

endmodule

// File: doc/instruction_queue.md
Name: instruction_queue

Overview:
FIFO between instruction fetch (IF) and instruction decode (ID).
- IF pushes fetched instruction words with their PCs; ID pops them in program order.
- The ROB flushes the queue on a branch misprediction.
- A slack-based full flag lets IF stop issuing new fetches while fetches already in flight (through the instruction cache and memory controller) still land safely.

Parameters:
DEPTH, 16, number of entries; power of two, >= 4
ADDR_W, 4, log2(DEPTH); width of head/tail pointers
SLACK, 2, free entries reserved for in-flight fetches; 1 <= SLACK < DEPTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rdy  in  1  global ready; low freezes all state
IF_inst_valid  in  1  push request: IF_inst/IF_pc valid this cycle
IF_inst  in  32  instruction word to enqueue
IF_pc  in  32  PC of IF_inst
IF_queue_is_full  out  1  backpressure to IF: stop issuing new fetches
ID_enable  in  1  pop request from ID
ID_queue_is_empty  out  1  no valid entry at head
ID_inst  out  32  head instruction (first-word fall-through)
ID_pc  out  32  head PC
ROB_clear  in  1  misprediction flush

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- State: entry arrays inst_mem[DEPTH], pc_mem[DEPTH]; head and tail pointers (ADDR_W bits); count (ADDR_W+1 bits).
- Reset (async, rst=1):
  - head=tail=count=0; entry contents don't-care.
  - Outputs: ID_queue_is_empty=1, IF_queue_is_full=0, ID_inst=0, ID_pc=0.
- Output flags, combinational from registered state:
  - ID_queue_is_empty = (count==0).
  - IF_queue_is_full = (count >= DEPTH-SLACK).
- Head outputs:
  - ID_inst/ID_pc = inst_mem[head]/pc_mem[head] when count!=0, else 0.
  - No bypass: an entry pushed in cycle N is visible at the head from cycle N+1.
- pop = ID_enable && count!=0. Popping an empty queue is ignored; state is unchanged.
- push = IF_inst_valid && (count<DEPTH || pop).
  - When full, a push in the same cycle as a pop is accepted.
  - A push to a full queue without a pop is dropped silently. This is a protocol violation; IF honours IF_queue_is_full, and SLACK covers fetches in flight.
- Update on posedge clk when rdy=1, in priority order:
  1. ROB_clear=1: head=tail=count=0. Any same-cycle push and pop are discarded.
  2. Otherwise:
     - push: write tail entry, tail=tail+1.
     - pop: head=head+1.
     - count = count + push - pop.
- Pointer arithmetic: both pointers wrap modulo DEPTH by natural ADDR_W overflow. count never exceeds DEPTH.
- rdy=0: no state changes, including ROB_clear, push and pop. Outputs hold their values.
- Simultaneous push+pop:
  - At count==0, only the push takes effect (pop is invalid).
  - At 0<count<=DEPTH, both take effect and count is unchanged.
- Reset mid-operation: asynchronous clear of pointers and count. Outputs take their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package/defines: InstBus (32), AddressBus (32), queue DEPTH/SLACK constants. These reuse the existing cpu_define entries.
- Sub-module: none. The storage array is inferred in this module; a separate RAM wrapper is not warranted at this size.

Test Plan:
- Reset then idle -> ID_queue_is_empty=1, IF_queue_is_full=0, ID_inst=0, ID_pc=0.
- Push {inst=0x00500093, pc=0x0} at cycle N, no pop:
  - At N+1: ID_inst=0x00500093, ID_pc=0x0, empty=0.
  - Pop at N+1 -> at N+2: empty=1.
- Push 14 entries (pc=0,4,...,52) with DEPTH=16, SLACK=2:
  - IF_queue_is_full=1 after the 14th push.
  - 2 more pushes are accepted (count=16).
  - A 17th push without a pop is dropped.
  - Popping all 16 returns pc 0..60 in order.
- Full queue, push pc=0x100 with a simultaneous pop: count stays 16, the old head leaves, and pc=0x100 is the last entry returned.
- Wrap-around: interleave 40 pushes and pops, keeping count<=3 -> the pop sequence equals the push sequence across pointer wrap.
- Flush and freeze:
  - count=5, assert ROB_clear with IF_inst_valid=1 and ID_enable=1 -> next cycle count=0, empty=1, the pushed word is absent.
  - Then rdy=0 with push active for 3 cycles -> count stays 0.
  - Async rst pulse mid-push -> empty=1 immediately.
